uart_tx_fifo: RTL and testbench

Transmit-side byte buffer placed directly upstream of the UART transmitter `TX_SEND`. It accepts bytes from a producer at full clock rate and drains them into the transmitter's `wen`/`din`/`rdy` handshake one frame at a time. Its purpose is to absorb bursts so the producer does not stall on every UART frame. It reports fill level, full/empty status and a sticky overflow flag.

---
 rtl/uart_tx_fifo.sv | 82 ++++++++
 tb/tb_uart_tx_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART transmitter's wen/din/rdy handshake.
// Absorbs producer bursts; reports fill level, full/empty and a sticky overflow flag.
module uart_tx_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          ovf_clr,
  input  logic          tx_rdy,
  output logic          tx_wen,
  output logic [DW-1:0] tx_din
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] FullCnt = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [Depth];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  // Status comes from the registered count only, so a same-cycle pop never frees a full slot.
  assign full   = (count_q == FullCnt);
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign tx_wen = ~empty;
  assign tx_din = mem[rd_ptr_q];

  assign push = wr_en & ~full;
  assign pop  = tx_wen & tx_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set wins over clear when both happen together.
    if (wr_en && full)  ovf_d = 1'b1;
    else if (ovf_clr)   ovf_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset; stale content is don't-care while empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full, empty;
  logic [AW:0]   count;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic          tx_rdy = 1'b0;
  logic          tx_wen;
  logic [DW-1:0] tx_din;

  int n_asserts = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_b;

  uart_tx_fifo #(.DW(DW), .AW(AW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .tx_rdy  (tx_rdy),
    .tx_wen  (tx_wen),
    .tx_din  (tx_din)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full),  32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ovf"},   32'(ovf),   32'd0);
    check({tag, "_wen"},   32'(tx_wen), 32'd0);
  endtask

  initial begin
    // Reset asserted mid-cycle for three cycles
    #2 RST = 1'b1;
    #1 check_idle("rst_during");
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    tick();
    check_idle("rst_after");

    // Single byte
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("single_count", 32'(count), 32'd1);
    check("single_wen", 32'(tx_wen), 32'd1);
    check("single_din", 32'(tx_din), 32'hA5);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    check("single_pop_count", 32'(count), 32'd0);
    check("single_pop_wen", 32'(tx_wen), 32'd0);

    // Fill 0x00..0x0F then drain in order
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    tx_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill_order", 32'(tx_din), 32'(i));
      tick();
    end
    tx_rdy = 1'b0;
    check("fill_drained_empty", 32'(empty), 32'd1);
    check("fill_drained_count", 32'(count), 32'd0);

    // Overflow: write while full with a same-cycle pop is dropped
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_en = 1'b1; wr_data = 8'hFF; tx_rdy = 1'b1;
    tick();
    wr_en = 1'b0; tx_rdy = 1'b0;
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd15);
    // Top back up to full, then overflow while clearing: set must win
    wr_en = 1'b1; wr_data = 8'h40;
    tick();
    check("ovf_refull", 32'(full), 32'd1);
    wr_data = 8'hFF; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_priority", 32'(ovf), 32'd1);
    check("ovf_full_count", 32'(count), 32'd16);
    tx_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'h31 + 8'(i);
      check("ovf_drain_order", 32'(tx_din), 32'(exp_b));
      tick();
    end
    tx_rdy = 1'b0;
    check("ovf_drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);

    // Simultaneous push/pop at count=1, long enough to wrap pointers
    wr_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_data = 8'h22; tx_rdy = 1'b1;
    check("sim_head", 32'(tx_din), 32'h11);
    tick();
    check("sim_count", 32'(count), 32'd1);
    check("sim_din", 32'(tx_din), 32'h22);
    exp_b = 8'h22;
    for (int i = 0; i < 40; i++) begin
      wr_data = 8'h23 + 8'(i);
      check("sim_loop_din", 32'(tx_din), 32'(exp_b));
      tick();
      check("sim_loop_count", 32'(count), 32'd1);
      exp_b = 8'h23 + 8'(i);
    end
    wr_en = 1'b0;
    check("sim_last_din", 32'(tx_din), 32'(exp_b));
    tick();
    tx_rdy = 1'b0;
    check("sim_final_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-operation discards queued bytes
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("midrst_pre_count", 32'(count), 32'd3);
    #2 RST = 1'b1;
    #1 check_idle("midrst");
    @(negedge CLK) RST = 1'b0;
    tick();
    check_idle("midrst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
